// File: rtl/bp_cfg_dump_tx_pkg.sv
// Shared types and constants for the configuration dump transmitter.
// BP_CFG_DUMP_CSUM_EN selects the trailing checksum word (changes the header word count).
package bp_cfg_dump_tx_pkg;

   localparam int unsigned max_cfgs_p       = 128;
   localparam int unsigned lg_max_cfgs      = $clog2(max_cfgs_p);
   localparam int unsigned num_valid_cfgs_p = 10;
   localparam int unsigned fld_count        = 41;
   localparam int unsigned fld_id_w         = 6;

   localparam logic [7:0]  hdr_id    = 8'hFF;
   localparam logic [7:0]  csum_id   = 8'hFE;
   localparam logic [15:0] cfg_magic = 16'hB9A7;

`ifdef BP_CFG_DUMP_CSUM_EN
   localparam int unsigned words_after_hdr = fld_count + 1;
`else
   localparam int unsigned words_after_hdr = fld_count;
`endif

   typedef enum logic [fld_id_w-1:0] {
      e_cfg_fld_cc_x_dim = 6'd1, e_cfg_fld_cc_y_dim, e_cfg_fld_ic_y_dim, e_cfg_fld_mc_y_dim,
      e_cfg_fld_cac_x_dim, e_cfg_fld_sac_x_dim, e_cfg_fld_cacc_type, e_cfg_fld_sacc_type,
      e_cfg_fld_num_cce, e_cfg_fld_num_lce, e_cfg_fld_vaddr_width, e_cfg_fld_paddr_width,
      e_cfg_fld_asid_width, e_cfg_fld_branch_metadata_fwd_width, e_cfg_fld_btb_tag_width,
      e_cfg_fld_btb_idx_width, e_cfg_fld_lce_assoc, e_cfg_fld_lce_sets, e_cfg_fld_cce_block_width,
      e_cfg_fld_num_cce_instr_ram_els, e_cfg_fld_icache_sets, e_cfg_fld_icache_assoc,
      e_cfg_fld_icache_block_width, e_cfg_fld_dcache_sets, e_cfg_fld_dcache_assoc,
      e_cfg_fld_dcache_block_width, e_cfg_fld_itlb_els, e_cfg_fld_dtlb_els, e_cfg_fld_lr_sc,
      e_cfg_fld_amo_swap, e_cfg_fld_amo_fetch_logic, e_cfg_fld_amo_fetch_arithmetic,
      e_cfg_fld_l2_en, e_cfg_fld_l2_sets, e_cfg_fld_l2_assoc, e_cfg_fld_fe_queue_fifo_els,
      e_cfg_fld_fe_cmd_fifo_els, e_cfg_fld_async_coh_clk, e_cfg_fld_coh_noc_flit_width,
      e_cfg_fld_io_noc_cid_width, e_cfg_fld_io_noc_len_width
   } bp_cfg_fld_e;

   // Member order must match bp_cfg_fld_e: field id 1 occupies the MSBs.
   typedef struct packed {
      logic [31:0] cc_x_dim, cc_y_dim, ic_y_dim, mc_y_dim;
      logic [31:0] cac_x_dim, sac_x_dim, cacc_type, sacc_type;
      logic [31:0] num_cce, num_lce, vaddr_width, paddr_width;
      logic [31:0] asid_width, branch_metadata_fwd_width, btb_tag_width;
      logic [31:0] btb_idx_width, lce_assoc, lce_sets, cce_block_width;
      logic [31:0] num_cce_instr_ram_els, icache_sets, icache_assoc;
      logic [31:0] icache_block_width, dcache_sets, dcache_assoc;
      logic [31:0] dcache_block_width, itlb_els, dtlb_els, lr_sc;
      logic [31:0] amo_swap, amo_fetch_logic, amo_fetch_arithmetic;
      logic [31:0] l2_en, l2_sets, l2_assoc, fe_queue_fifo_els;
      logic [31:0] fe_cmd_fifo_els, async_coh_clk, coh_noc_flit_width;
      logic [31:0] io_noc_cid_width, io_noc_len_width;
   } bp_proc_param_s;

   // Configuration table: entry 0 is the invalid config, 1..9 are the populated builds.
   function automatic bp_proc_param_s cfg_lookup(input logic [lg_max_cfgs-1:0] idx);
      bp_proc_param_s c;
      c.cc_x_dim = 32'd1;  c.cc_y_dim = 32'd1;  c.ic_y_dim = 32'd1;  c.mc_y_dim = 32'd0;
      c.cac_x_dim = 32'd0; c.sac_x_dim = 32'd0; c.cacc_type = 32'd0; c.sacc_type = 32'd0;
      c.num_cce = 32'd1;   c.num_lce = 32'd2;   c.vaddr_width = 32'd39; c.paddr_width = 32'd40;
      c.asid_width = 32'd1; c.branch_metadata_fwd_width = 32'd36; c.btb_tag_width = 32'd9;
      c.btb_idx_width = 32'd6; c.lce_assoc = 32'd8; c.lce_sets = 32'd64; c.cce_block_width = 32'd512;
      c.num_cce_instr_ram_els = 32'd256; c.icache_sets = 32'd64; c.icache_assoc = 32'd8;
      c.icache_block_width = 32'd512; c.dcache_sets = 32'd64; c.dcache_assoc = 32'd8;
      c.dcache_block_width = 32'd512; c.itlb_els = 32'd8; c.dtlb_els = 32'd8; c.lr_sc = 32'd1;
      c.amo_swap = 32'd0; c.amo_fetch_logic = 32'd0; c.amo_fetch_arithmetic = 32'd0;
      c.l2_en = 32'd1; c.l2_sets = 32'd128; c.l2_assoc = 32'd8; c.fe_queue_fifo_els = 32'd16;
      c.fe_cmd_fifo_els = 32'd8; c.async_coh_clk = 32'd0; c.coh_noc_flit_width = 32'd128;
      c.io_noc_cid_width = 32'd2; c.io_noc_len_width = 32'd4;
      case (idx)
         7'd0: c = bp_proc_param_s'({fld_count{32'd1}});
         7'd2: begin c.lce_assoc = 32'd4; c.icache_assoc = 32'd4; c.dcache_assoc = 32'd4; end
         7'd3: begin c.cc_x_dim = 32'd2; c.num_cce = 32'd2;  c.num_lce = 32'd4;  end
         7'd4: begin c.cc_x_dim = 32'd3; c.num_cce = 32'd3;  c.num_lce = 32'd6;  end
         7'd5: begin c.cc_x_dim = 32'd2; c.cc_y_dim = 32'd2; c.num_cce = 32'd4;  c.num_lce = 32'd8;  end
         7'd6: begin c.cc_x_dim = 32'd3; c.cc_y_dim = 32'd2; c.num_cce = 32'd6;  c.num_lce = 32'd12; end
         7'd7: begin c.cc_x_dim = 32'd4; c.cc_y_dim = 32'd2; c.num_cce = 32'd8;  c.num_lce = 32'd16; end
         7'd8: begin c.cc_x_dim = 32'd4; c.cc_y_dim = 32'd3; c.num_cce = 32'd12; c.num_lce = 32'd24; end
         7'd9: begin
            c.cc_x_dim = 32'd4; c.cc_y_dim = 32'd4; c.num_cce = 32'd16; c.num_lce = 32'd32;
            c.io_noc_cid_width = 32'd1;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [63:0] make_hdr(input logic [lg_max_cfgs-1:0] idx, input logic inv);
      return {hdr_id, cfg_magic, 8'(idx), 8'(words_after_hdr), 23'd0, inv};
   endfunction

endpackage

// File: rtl/bp_cfg_field_mux.sv
// Combinational selector: returns the 32-bit value of one configuration field by id.
module bp_cfg_field_mux
   import bp_cfg_dump_tx_pkg::*;
(
   input  bp_proc_param_s        i_cfg,
   input  logic [fld_id_w-1:0]   i_fld_id,
   output logic [31:0]           o_val_c
);
   localparam int unsigned flat_w_lp = $bits(bp_proc_param_s);
   localparam int unsigned lsb_w_lp  = $clog2(flat_w_lp);

   logic [flat_w_lp-1:0] w_flat;
   logic [fld_id_w-1:0]  w_slot;
   logic [lsb_w_lp-1:0]  w_lsb;

   assign w_flat = i_cfg;
   assign w_slot = fld_id_w'(fld_count) - i_fld_id;
   assign w_lsb  = lsb_w_lp'({w_slot, 5'd0});

   always_comb begin
      o_val_c = '0;
      if (i_fld_id >= e_cfg_fld_cc_x_dim && i_fld_id <= e_cfg_fld_io_noc_len_width)
         o_val_c = w_flat[w_lsb +: 32];
   end

endmodule

// File: rtl/bp_cfg_dump_tx.sv
// Streams one configuration-table entry as a header word followed by one word per field.
// Defining BP_CFG_DUMP_CSUM_EN appends a checksum word after the last field.
module bp_cfg_dump_tx
   import bp_cfg_dump_tx_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [lg_max_cfgs-1:0] cfg_sel_i,
   input  logic                   start_v_i,
   output logic                   start_ready_o,
   output logic [63:0]            data_o,
   output logic                   v_o,
   input  logic                   ready_i,
   output logic                   last_o,
   output logic                   done_o
);

`ifdef BP_CFG_DUMP_CSUM_EN
   typedef enum logic [1:0] {s_idle, s_hdr, s_field, s_csum} state_e;
`else
   typedef enum logic [1:0] {s_idle, s_hdr, s_field} state_e;
`endif

   state_e                 r_state, w_state_nxt;
   logic [fld_id_w-1:0]    r_cnt, w_cnt_nxt;
   logic [lg_max_cfgs-1:0] r_idx, w_idx_nxt;
   logic [63:0]            r_data, w_data_nxt;
   logic                   r_v, w_v_nxt;
   logic                   r_last, w_last_nxt;
   logic                   r_done, w_done_nxt;
`ifdef BP_CFG_DUMP_CSUM_EN
   logic [31:0]            r_csum, w_csum_nxt;
`endif

   logic                   w_fire;
   logic                   w_sel_ok;
   logic [fld_id_w-1:0]    w_fld_id;
   logic [31:0]            w_fld_val;
   bp_proc_param_s         w_cfg;

   assign w_fire   = r_v & ready_i;
   assign w_sel_ok = cfg_sel_i < lg_max_cfgs'(num_valid_cfgs_p);
   assign w_fld_id = r_cnt + fld_id_w'(1);
   assign w_cfg    = cfg_lookup(r_idx);

   bp_cfg_field_mux u_field_mux (
      .i_cfg    (w_cfg),
      .i_fld_id (w_fld_id),
      .o_val_c  (w_fld_val)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_v_nxt     = r_v;
      w_last_nxt  = r_last;
      w_done_nxt  = 1'b0;
`ifdef BP_CFG_DUMP_CSUM_EN
      w_csum_nxt  = r_csum;
      if (w_fire && r_state != s_csum) w_csum_nxt = r_csum + r_data[31:0];
`endif
      case (r_state)
         s_idle: if (start_v_i) begin
            // Out-of-range selects dump the invalid config (entry 0) with the flag set
            w_idx_nxt   = w_sel_ok ? cfg_sel_i : '0;
            w_data_nxt  = make_hdr(w_idx_nxt, !w_sel_ok);
            w_v_nxt     = 1'b1;
            w_last_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = s_hdr;
`ifdef BP_CFG_DUMP_CSUM_EN
            w_csum_nxt  = '0;
`endif
         end
         s_hdr, s_field: if (w_fire) begin
            if (r_cnt == fld_id_w'(fld_count)) begin
`ifdef BP_CFG_DUMP_CSUM_EN
               w_state_nxt = s_csum;
               w_data_nxt  = {csum_id, 24'd0, r_csum + r_data[31:0]};
               w_last_nxt  = 1'b1;
`else
               w_state_nxt = s_idle;
               w_cnt_nxt   = '0;
               w_data_nxt  = '0;
               w_v_nxt     = 1'b0;
               w_last_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
`endif
            end else begin
               w_state_nxt = s_field;
               w_cnt_nxt   = w_fld_id;
               w_data_nxt  = {2'b00, w_fld_id, 24'd0, w_fld_val};
`ifdef BP_CFG_DUMP_CSUM_EN
               w_last_nxt  = 1'b0;
`else
               w_last_nxt  = (w_fld_id == fld_id_w'(fld_count));
`endif
            end
         end
`ifdef BP_CFG_DUMP_CSUM_EN
         s_csum: if (w_fire) begin
            w_state_nxt = s_idle;
            w_cnt_nxt   = '0;
            w_data_nxt  = '0;
            w_v_nxt     = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= s_idle;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_v     <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_v     <= w_v_nxt;
         r_last  <= w_last_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef BP_CFG_DUMP_CSUM_EN
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) r_csum <= '0;
      else            r_csum <= w_csum_nxt;
   end
`endif

   assign start_ready_o = (r_state == s_idle);
   assign data_o        = r_data;
   assign v_o           = r_v;
   assign last_o        = r_last;
   assign done_o        = r_done;

endmodule
